// File: rtl/vector_load_gather.sv
// Memory-stage load gather: one word per cycle from a 1-cycle-latency read port into a V-bit vector.
// Optional macro DMEM_BOUNDS_CHECK_EN suppresses and flags lanes whose address is >= SIZE.
module vector_load_gather #(
    parameter int S    = 32,
    parameter int V    = 192,
    parameter int SIZE = 30000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [S-1:0] req_addr,
    input  logic         req_isVector,
    output logic         mem_en,
    output logic [S-1:0] mem_addr,
    input  logic [S-1:0] mem_rdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [V-1:0] rsp_data,
    output logic         busy,
    output logic         err
);

    localparam int LANES  = V / S;
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic [S-1:0]       base;
    logic               is_vec;
    logic [LANE_W-1:0]  idx;
    logic [LANE_W-1:0]  last_idx;
    logic [LANE_W-1:0]  cap_lane;
    logic               cap_valid;
    logic               cap_skip;
    logic               err_q;
    logic               oob;
    logic [S-1:0]       issue_addr;

    assign last_idx   = is_vec ? LANE_W'(LANES - 1) : '0;
    assign issue_addr = base + {{(S-LANE_W){1'b0}}, idx};

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [S:0] SIZE_EXT = (S+1)'(SIZE);
    logic [S:0] lane_addr_ext;
    // Unwrapped address: a lane that wraps past 2^S is out of range, not aliased to low memory.
    assign lane_addr_ext = {1'b0, base} + {{(S+1-LANE_W){1'b0}}, idx};
    assign oob           = (state == ISSUE) && (lane_addr_ext >= SIZE_EXT);
`else
    assign oob = 1'b0;
`endif

    assign err = err_q && (state == RESP);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        rsp_valid  = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_next = ISSUE;
            end
            ISSUE: begin
                mem_en   = !oob;
                mem_addr = issue_addr;
                if (idx == last_idx) state_next = WAIT;
            end
            WAIT: state_next = RESP;
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: rsp_data is a plain register bank, so it is reset; an aborted transfer must not leak lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base      <= '0;
            is_vec    <= 1'b0;
            idx       <= '0;
            cap_lane  <= '0;
            cap_valid <= 1'b0;
            cap_skip  <= 1'b0;
            err_q     <= 1'b0;
            rsp_data  <= '0;
        end else begin
            cap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base     <= req_addr;
                        is_vec   <= req_isVector;
                        idx      <= '0;
                        err_q    <= 1'b0;
                        rsp_data <= '0;
                    end
                end
                ISSUE: begin
                    idx       <= idx + 1'b1;
                    cap_valid <= 1'b1;
                    cap_lane  <= idx;
                    cap_skip  <= oob;
                    if (oob) err_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) err_q <= 1'b0;
                end
                default: ;
            endcase

            // Read data for the slot issued last cycle lands now; suppressed slots stay zero.
            if (cap_valid && !cap_skip) begin
                for (int i = 0; i < LANES; i++) begin
                    if (cap_lane == LANE_W'(i)) rsp_data[i*S +: S] <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_vector_load_gather.sv
// Scoreboard bench for vector_load_gather: memory model returns 3*addr, expectations queued at request time.
// Expectations follow DMEM_BOUNDS_CHECK_EN when the macro is defined for the build.
module tb_vector_load_gather;

    localparam int S    = 32;
    localparam int V    = 192;
    localparam int SIZE = 30000;
`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [S-1:0] req_addr;
    logic         req_isVector;
    logic         mem_en;
    logic [S-1:0] mem_addr;
    logic [S-1:0] mem_rdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [V-1:0] rsp_data;
    logic         busy;
    logic         err;

    int checks = 0;
    int errors = 0;

    logic [V-1:0] exp_data_q[$];
    logic         exp_err_q[$];
    logic [S-1:0] issue_q[$];

    vector_load_gather #(.S(S), .V(V), .SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_isVector (req_isVector),
        .mem_en       (mem_en),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Backing memory: mem[a] = 3*a; garbage when no read was issued so suppressed lanes show up.
    always @(posedge clk) begin
        if (mem_en) mem_rdata <= mem_addr * 32'd3;
        else        mem_rdata <= 32'hbad0_0bad;
    end

    always @(negedge clk) begin
        if (rst_n && mem_en) issue_q.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [V-1:0] act, input logic [V-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic lane_oob(input logic [S-1:0] addr, input int i);
        logic [S:0] ua;
        ua = {1'b0, addr} + (S+1)'(i);
        return BOUNDS && (ua >= (S+1)'(SIZE));
    endfunction

    function automatic logic [V-1:0] exp_data(input logic [S-1:0] addr, input logic vec);
        logic [V-1:0] d;
        logic [S-1:0] wa;
        d = '0;
        for (int i = 0; i < (vec ? 6 : 1); i++) begin
            wa = addr + S'(i);
            if (!lane_oob(addr, i)) d[i*S +: S] = wa * 32'd3;
        end
        return d;
    endfunction

    function automatic logic exp_err(input logic [S-1:0] addr, input logic vec);
        logic e;
        e = 1'b0;
        for (int i = 0; i < (vec ? 6 : 1); i++) e |= lane_oob(addr, i);
        return e;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rsp_valid"}, V'(rsp_valid), V'(0));
        check({tag, "_rsp_data"},  rsp_data,      V'(0));
        check({tag, "_mem_en"},    V'(mem_en),    V'(0));
        check({tag, "_req_ready"}, V'(req_ready), V'(1));
        check({tag, "_busy"},      V'(busy),      V'(0));
        check({tag, "_err"},       V'(err),       V'(0));
    endtask

    task automatic accept(input logic [S-1:0] addr, input logic vec);
        @(negedge clk);
        req_valid    = 1'b1;
        req_addr     = addr;
        req_isVector = vec;
        check("accept_req_ready", V'(req_ready), V'(1));
        exp_data_q.push_back(exp_data(addr, vec));
        exp_err_q.push_back(exp_err(addr, vec));
        issue_q.delete();
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_addr     = 32'hdead_beef;
        req_isVector = ~vec;
    endtask

    task automatic wait_rsp(input int n);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", V'(lat), V'(n + 1));
    endtask

    task automatic complete(input logic [S-1:0] addr, input logic vec);
        int k;
        logic [S-1:0] wa;
        check("rsp_valid", V'(rsp_valid), V'(1));
        if (exp_data_q.size() == 0) begin
            check("scoreboard_empty", V'(1), V'(0));
        end else begin
            check("rsp_data", rsp_data, exp_data_q.pop_front());
            check("rsp_err", V'(err), V'(exp_err_q.pop_front()));
        end
        k = 0;
        for (int i = 0; i < (vec ? 6 : 1); i++) begin
            if (!lane_oob(addr, i)) begin
                wa = addr + S'(i);
                if (k < issue_q.size()) check("issue_addr", V'(issue_q[k]), V'(wa));
                k++;
            end
        end
        check("issue_count", V'(issue_q.size()), V'(k));
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", V'(rsp_valid), V'(0));
        check("post_hs_err", V'(err), V'(0));
        check("post_hs_req_ready", V'(req_ready), V'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [V-1:0] snap;
        int k;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_isVector = 1'b0;
        rsp_ready    = 1'b0;
        #12;
        check_idle("reset");
        check("reset_mem_addr", V'(mem_addr), V'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Scalar load
        accept(32'd10, 1'b0);
        wait_rsp(1);
        complete(32'd10, 1'b0);

        // Vector load
        accept(32'd100, 1'b1);
        wait_rsp(6);
        complete(32'd100, 1'b1);

        // Backpressure with a competing request held on the input
        accept(32'd100, 1'b1);
        wait_rsp(6);
        snap = rsp_data;
        @(negedge clk);
        req_valid    = 1'b1;
        req_addr     = 32'd200;
        req_isVector = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_data_stable", rsp_data, snap);
            check("bp_req_ready", V'(req_ready), V'(0));
            check("bp_rsp_valid", V'(rsp_valid), V'(1));
        end
        check("bp_no_issue", V'(issue_q.size()), V'(6));
        complete(32'd100, 1'b1);
        exp_data_q.push_back(exp_data(32'd200, 1'b0));
        exp_err_q.push_back(exp_err(32'd200, 1'b0));
        issue_q.delete();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("bp_second_accept", V'(busy), V'(1));
        wait_rsp(1);
        complete(32'd200, 1'b0);

        // Reset in the middle of a vector transfer
        accept(32'd100, 1'b1);
        k = 0;
        while (issue_q.size() < 3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_issues", V'(issue_q.size()), V'(3));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        void'(exp_data_q.pop_back());
        void'(exp_err_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        accept(32'd4, 1'b0);
        wait_rsp(1);
        complete(32'd4, 1'b0);

        // Bounds edge and 32-bit address wrap
        accept(32'd29997, 1'b1);
        wait_rsp(6);
        complete(32'd29997, 1'b1);
        accept(32'hffff_fffe, 1'b1);
        wait_rsp(6);
        complete(32'hffff_fffe, 1'b1);

        // Last in-range word as a scalar
        accept(32'd29999, 1'b0);
        wait_rsp(1);
        complete(32'd29999, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
